// File: rtl/count_minute.sv
// ============================================================================
// Module      : count_minute
// Description : Seconds/minutes counter driven by an edge-detected 1 Hz level,
//               with minute set/commit and an hour-carry level output.
//               Define CLOCK_SEC_SYNC_EN to add a two-flop sec1sig synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_minute (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec1sig,
  input  logic [1:0] state,
  input  logic [5:0] num,
  input  logic       min_enable,
  output logic [5:0] sec_count,
  output logic [5:0] min_count,
  output logic       min60sig
);

  localparam logic [1:0] c_ST_TIMING = 2'b00;
  localparam logic [1:0] c_ST_SET_A  = 2'b01;
  localparam logic [1:0] c_ST_SET_B  = 2'b10;
  localparam logic [1:0] c_ST_COMMIT = 2'b11;
  localparam logic [5:0] c_MAX_VAL   = 6'd59;

`ifdef CLOCK_SEC_SYNC_EN
  localparam int c_VLD_LEN = 4;

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= sec1sig;
      r_sync2 <= r_sync1;
    end
  end

  logic w_sec_in;
  assign w_sec_in = r_sync2;
`else
  localparam int c_VLD_LEN = 2;

  logic w_sec_in;
  assign w_sec_in = sec1sig;
`endif

  logic                 r_samp_cur;
  logic                 r_samp_prev;
  logic [c_VLD_LEN-1:0] r_vld;
  logic [5:0]           r_shadow;
  logic                 w_tick;

  // r_vld masks ticks until the whole sample pipeline holds real post-reset
  // samples, so a level already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_cur  <= 1'b0;
      r_samp_prev <= 1'b0;
      r_vld       <= '0;
    end else begin
      r_samp_cur  <= w_sec_in;
      r_samp_prev <= r_samp_cur;
      r_vld       <= {r_vld[c_VLD_LEN-2:0], 1'b1};
    end
  end

  assign w_tick = r_samp_cur & ~r_samp_prev & r_vld[c_VLD_LEN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_count <= 6'd0;
      min_count <= 6'd0;
      min60sig  <= 1'b0;
      r_shadow  <= 6'd0;
    end else begin
      case (state)
        c_ST_TIMING: begin
          if (w_tick) begin
            min60sig <= 1'b0;
            if (sec_count == c_MAX_VAL) begin
              sec_count <= 6'd0;
              if (min_count == c_MAX_VAL) begin
                min_count <= 6'd0;
                min60sig  <= 1'b1;
              end else begin
                min_count <= min_count + 6'd1;
              end
            end else begin
              sec_count <= sec_count + 6'd1;
            end
          end
        end
        c_ST_SET_A, c_ST_SET_B: begin
          min60sig <= 1'b0;
          if (min_enable && (num <= c_MAX_VAL)) begin
            r_shadow <= num;
          end
        end
        c_ST_COMMIT: begin
          min60sig <= 1'b0;
          if (min_enable) begin
            min_count <= r_shadow;
            sec_count <= 6'd0;
          end
        end
        default: begin
          min60sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_count_minute.sv
// ============================================================================
// Module      : tb_count_minute
// Description : Directed self-checking bench for count_minute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_minute;

  logic       clk;
  logic       rst;
  logic       sec1sig;
  logic [1:0] state;
  logic [5:0] num;
  logic       min_enable;
  logic [5:0] sec_count;
  logic [5:0] min_count;
  logic       min60sig;

  int total;
  int bad;

`ifdef CLOCK_SEC_SYNC_EN
  localparam bit c_SYNC = 1'b1;
`else
  localparam bit c_SYNC = 1'b0;
`endif

  count_minute dut (
    .clk        (clk),
    .rst        (rst),
    .sec1sig    (sec1sig),
    .state      (state),
    .num        (num),
    .min_enable (min_enable),
    .sec_count  (sec_count),
    .min_count  (min_count),
    .min60sig   (min60sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      sec1sig = 1'b1;
      step(4);
      sec1sig = 1'b0;
      step(4);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_min(input logic [5:0] v);
    state = 2'b01; min_enable = 1'b1; num = v;
    step(2);
    state = 2'b11;
    step(1);
    state = 2'b00;
    step(1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; sec1sig = 1'b0; state = 2'b00; num = 6'd0; min_enable = 1'b0;
    step(3);
    chk("rst_sec", {2'b0, sec_count}, 8'd0);
    chk("rst_min", {2'b0, min_count}, 8'd0);
    chk("rst_c60", {7'b0, min60sig}, 8'd0);
    rst = 1'b0;
    step(6);

    // Tick latency from a single rise
    sec1sig = 1'b1;
    step(1);
    chk("lat_n", {2'b0, sec_count}, 8'd0);
    step(1);
    chk("lat_n1", {2'b0, sec_count}, c_SYNC ? 8'd0 : 8'd1);
    step(2);
    chk("lat_n3", {2'b0, sec_count}, 8'd1);
    sec1sig = 1'b0;
    step(4);

    // One full minute of seconds
    pulse(58);
    chk("m1_sec59", {2'b0, sec_count}, 8'd59);
    chk("m1_min0", {2'b0, min_count}, 8'd0);
    pulse(1);
    chk("m1_sec0", {2'b0, sec_count}, 8'd0);
    chk("m1_min1", {2'b0, min_count}, 8'd1);
    chk("m1_c60", {7'b0, min60sig}, 8'd0);

    // Set/commit 42, then an out-of-range value is ignored
    pulse(2);
    set_min(6'd42);
    chk("set42_min", {2'b0, min_count}, 8'd42);
    chk("set42_sec", {2'b0, sec_count}, 8'd0);
    chk("set42_c60", {7'b0, min60sig}, 8'd0);
    set_min(6'd63);
    chk("set63_min", {2'b0, min_count}, 8'd42);

    // Disabled set/commit and ticks outside timing mode
    min_enable = 1'b0;
    pulse(3);
    chk("run3_sec", {2'b0, sec_count}, 8'd3);
    state = 2'b10; num = 6'd15;
    pulse(2);
    chk("st10_sec", {2'b0, sec_count}, 8'd3);
    state = 2'b11;
    step(2);
    chk("dis_min", {2'b0, min_count}, 8'd42);
    chk("dis_sec", {2'b0, sec_count}, 8'd3);
    state = 2'b00;
    step(1);

    // Hour carry from 59:58
    set_min(6'd59);
    min_enable = 1'b0;
    pulse(58);
    chk("pre_sec", {2'b0, sec_count}, 8'd58);
    chk("pre_min", {2'b0, min_count}, 8'd59);
    pulse(1);
    chk("p1_sec", {2'b0, sec_count}, 8'd59);
    pulse(1);
    chk("wrap_sec", {2'b0, sec_count}, 8'd0);
    chk("wrap_min", {2'b0, min_count}, 8'd0);
    chk("wrap_c60", {7'b0, min60sig}, 8'd1);
    step(3);
    chk("hold_c60", {7'b0, min60sig}, 8'd1);
    pulse(1);
    chk("next_sec", {2'b0, sec_count}, 8'd1);
    chk("next_c60", {7'b0, min60sig}, 8'd0);

    // Carry cleared by leaving timing mode
    set_min(6'd59);
    min_enable = 1'b0;
    pulse(60);
    chk("c2_c60", {7'b0, min60sig}, 8'd1);
    state = 2'b01;
    step(1);
    chk("c2_clr", {7'b0, min60sig}, 8'd0);
    chk("c2_min", {2'b0, min_count}, 8'd0);
    state = 2'b00;
    step(1);

    // Asynchronous reset mid-count with sec1sig held high
    set_min(6'd30);
    min_enable = 1'b0;
    pulse(20);
    chk("r2_sec", {2'b0, sec_count}, 8'd20);
    chk("r2_min", {2'b0, min_count}, 8'd30);
    sec1sig = 1'b1;
    step(1);
    rst = 1'b1;
    #2;
    chk("ar_sec", {2'b0, sec_count}, 8'd0);
    chk("ar_min", {2'b0, min_count}, 8'd0);
    chk("ar_c60", {7'b0, min60sig}, 8'd0);
    step(2);
    rst = 1'b0;
    step(8);
    chk("rel_hi", {2'b0, sec_count}, 8'd0);
    sec1sig = 1'b0;
    step(4);
    sec1sig = 1'b1;
    step(4);
    chk("rel_rise", {2'b0, sec_count}, 8'd1);
    sec1sig = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
